quad_decoder: RTL and testbench

Quadrature encoder front-end that turns two asynchronous phase inputs (A, B) into a single-cycle `step` strobe plus a `dir` level. It sits directly upstream of the up/down counter: `step` drives the counter's enable and `dir` drives its direction. It also flags and counts illegal (double-edge) transitions.

---
 rtl/quad_pkg.sv | 32 +++
 rtl/quad_phase_filter.sv | 50 +++++
 rtl/quad_decoder.sv | 114 +++++++++++
 tb/tb_quad_decoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types for the quadrature decoder: phase-pair states, resolution modes
// and the helper that recognises one forward step of the Gray sequence.
package quad_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } quad_state_e;

  typedef enum logic [1:0] {
    X1 = 2'b00,
    X2 = 2'b01,
    X4 = 2'b10
  } quad_mode_e;

  // Forward (A leads B) order is 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic is_up(input quad_state_e prev, input quad_state_e cur);
    logic r;
    r = 1'b0;
    case (prev)
      S00:     r = (cur == S10);
      S10:     r = (cur == S11);
      S11:     r = (cur == S01);
      S01:     r = (cur == S00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_phase_filter.sv
// Two-flop synchroniser followed by a debounce counter: the filtered level only
// follows the synced input after it has differed for FILTER_CYCLES cycles.
module quad_phase_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic filt_out
);

  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_out = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature front-end: filtered A/B phases are compared against the previous
// state to produce step/dir strobes for a counter and to flag double-edge errors.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int FILTER_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a_in,
  input  logic             b_in,
  input  logic [1:0]       mode,
  input  logic             clr_err,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  localparam int SETTLE_W = $clog2(FILTER_CYCLES + 4);
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(FILTER_CYCLES + 3);

  logic        a_filt, b_filt;
  quad_state_e cur_state;
  quad_state_e prev_q, prev_d;
  logic [1:0]  delta;
  logic        up, dn, keep, live;

  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                evt_step_q, evt_step_d;
  logic                evt_up_q, evt_up_d;
  logic                evt_err_q, evt_err_d;
  logic                step_q, step_d;
  logic                dir_q, dir_d;
  logic                err_q, err_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

  quad_phase_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (a_in),
    .filt_out (a_filt)
  );

  quad_phase_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (b_in),
    .filt_out (b_filt)
  );

  assign cur_state = quad_state_e'({a_filt, b_filt});

  // Stage 1 classifies the transition; stage 2 registers the outputs. The
  // previous state always tracks, so disabled or settling cycles leave no debt.
  always_comb begin
    prev_d   = cur_state;
    settle_d = (settle_q == '0) ? settle_q : settle_q - SETTLE_W'(1);
    live     = en && (settle_q == '0);
    delta    = prev_q ^ cur_state;
    up       = is_up(prev_q, cur_state);
    dn       = is_up(cur_state, prev_q);
    case (mode)
      X1:      keep = (up && prev_q == S00) || (dn && prev_q == S10);
      X2:      keep = delta[1];
      default: keep = 1'b1;
    endcase
    evt_step_d = live && (up || dn) && keep;
    evt_up_d   = up;
    evt_err_d  = live && (delta == 2'b11);

    step_d    = evt_step_q && en;
    err_d     = evt_err_q && en;
    dir_d     = step_d ? evt_up_q : dir_q;
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= S00;
      settle_q   <= SETTLE_INIT;
      evt_step_q <= 1'b0;
      evt_up_q   <= 1'b0;
      evt_err_q  <= 1'b0;
      step_q     <= 1'b0;
      dir_q      <= 1'b1;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      prev_q     <= prev_d;
      settle_q   <= settle_d;
      evt_step_q <= evt_step_d;
      evt_up_q   <= evt_up_d;
      evt_err_q  <= evt_err_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign step      = step_q;
  assign dir       = dir_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: a table of held A/B levels with expected
// pulse counts, plus hand-written latency, glitch, error and reset sequences.
module tb_quad_decoder;

  localparam int FILTER_CYCLES = 4;
  localparam int ERR_W         = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             a_in;
  logic             b_in;
  logic [1:0]       mode;
  logic             clr_err;
  logic             step;
  logic             dir;
  logic             err;
  logic [ERR_W-1:0] err_count;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic       a;
    logic       b;
    logic [1:0] mode;
    logic       en;
    int         steps;
    int         errs;
    logic       dir;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  quad_decoder #(.FILTER_CYCLES(FILTER_CYCLES), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .a_in      (a_in),
    .b_in      (b_in),
    .mode      (mode),
    .clr_err   (clr_err),
    .step      (step),
    .dir       (dir),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds one A/B level for a number of cycles and counts the resulting pulses.
  task automatic apply_stimulus(input logic a, input logic b, input int cycles,
                                output int steps, output int errs, output int ups);
    a_in  = a;
    b_in  = b;
    steps = 0;
    errs  = 0;
    ups   = 0;
    repeat (cycles) begin
      tick();
      if (step) begin
        steps++;
        if (dir) ups++;
      end
      if (err) errs++;
    end
  endtask

  function automatic void add_vec(input logic a, input logic b, input logic [1:0] m,
                                  input logic e, input int s, input int er,
                                  input logic d, input int c);
    vec_t v;
    v = '{a: a, b: b, mode: m, en: e, steps: s, errs: er, dir: d, cnt: c};
    vecs.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, e, u, total_errs;

    // forward x4, reverse x4 (mode 11 alias), reverse x2, reverse x1
    add_vec(1, 0, 2'b10, 1, 1, 0, 1, 0);
    add_vec(1, 1, 2'b10, 1, 1, 0, 1, 0);
    add_vec(0, 1, 2'b10, 1, 1, 0, 1, 0);
    add_vec(0, 0, 2'b10, 1, 1, 0, 1, 0);
    add_vec(0, 1, 2'b11, 1, 1, 0, 0, 0);
    add_vec(1, 1, 2'b11, 1, 1, 0, 0, 0);
    add_vec(1, 0, 2'b11, 1, 1, 0, 0, 0);
    add_vec(0, 0, 2'b11, 1, 1, 0, 0, 0);
    add_vec(0, 1, 2'b01, 1, 0, 0, 0, 0);
    add_vec(1, 1, 2'b01, 1, 1, 0, 0, 0);
    add_vec(1, 0, 2'b01, 1, 0, 0, 0, 0);
    add_vec(0, 0, 2'b01, 1, 1, 0, 0, 0);
    add_vec(0, 1, 2'b00, 1, 0, 0, 0, 0);
    add_vec(1, 1, 2'b00, 1, 0, 0, 0, 0);
    add_vec(1, 0, 2'b00, 1, 0, 0, 0, 0);
    add_vec(0, 0, 2'b00, 1, 1, 0, 0, 0);
    // double-edge transitions
    add_vec(1, 1, 2'b10, 1, 0, 1, 0, 1);
    add_vec(0, 0, 2'b10, 1, 0, 1, 0, 2);
    // x1 forward then back
    add_vec(1, 0, 2'b00, 1, 1, 0, 1, 2);
    add_vec(0, 0, 2'b00, 1, 1, 0, 0, 2);
    // disabled transitions, re-enable, then resume
    add_vec(1, 0, 2'b10, 0, 0, 0, 0, 2);
    add_vec(1, 1, 2'b10, 0, 0, 0, 0, 2);
    add_vec(1, 1, 2'b10, 1, 0, 0, 0, 2);
    add_vec(0, 1, 2'b10, 1, 1, 0, 1, 2);
    add_vec(0, 0, 2'b10, 1, 1, 0, 1, 2);

    rst     = 1'b1;
    en      = 1'b1;
    a_in    = 1'b0;
    b_in    = 1'b0;
    clr_err = 1'b0;
    mode    = 2'b10;
    repeat (3) tick();
    check_output("reset step", int'(step), 0);
    check_output("reset dir", int'(dir), 1);
    check_output("reset err", int'(err), 0);
    check_output("reset err_count", int'(err_count), 0);
    rst = 1'b0;
    apply_stimulus(0, 0, 12, s, e, u);
    check_output("idle after reset steps", s, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      mode = vecs[i].mode;
      en   = vecs[i].en;
      apply_stimulus(vecs[i].a, vecs[i].b, 8, s, e, u);
      check_output($sformatf("vec%0d steps", i), s, vecs[i].steps);
      check_output($sformatf("vec%0d errs", i), e, vecs[i].errs);
      check_output($sformatf("vec%0d dir", i), int'(dir), int'(vecs[i].dir));
      check_output($sformatf("vec%0d err_count", i), int'(err_count), vecs[i].cnt);
    end

    // step appears after edge 3+FILTER_CYCLES counted from the first sampling edge
    a_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_output($sformatf("latency edge%0d step", k - 1), int'(step), (k == 8) ? 1 : 0);
    end
    apply_stimulus(0, 0, 12, s, e, u);
    check_output("latency return steps", s, 1);
    check_output("latency return ups", u, 0);

    a_in = 1'b1;
    repeat (3) tick();
    apply_stimulus(0, 0, 15, s, e, u);
    check_output("glitch3 steps", s, 0);
    check_output("glitch3 errs", e, 0);

    a_in = 1'b1;
    repeat (4) tick();
    apply_stimulus(0, 0, 16, s, e, u);
    check_output("pulse4 steps", s, 2);
    check_output("pulse4 ups", u, 1);
    check_output("pulse4 errs", e, 0);

    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_output("clr err_count", int'(err_count), 0);
    apply_stimulus(1, 1, 8, s, e, u);
    check_output("single err pulses", e, 1);
    check_output("single err steps", s, 0);
    check_output("single err_count", int'(err_count), 1);

    total_errs = 0;
    for (int i = 1; i < 300; i++) begin
      apply_stimulus((i % 2) == 0, (i % 2) == 0, 8, s, e, u);
      total_errs += e;
    end
    check_output("saturation err pulses", total_errs, 299);
    check_output("saturation err_count", int'(err_count), 255);

    // clear lands on the same edge as an illegal transition
    a_in = 1'b1;
    b_in = 1'b1;
    repeat (7) tick();
    clr_err = 1'b1;
    tick();
    check_output("clr collision err", int'(err), 1);
    check_output("clr collision err_count", int'(err_count), 0);
    clr_err = 1'b0;
    apply_stimulus(1, 1, 4, s, e, u);
    check_output("clr collision after", int'(err_count), 0);

    apply_stimulus(0, 0, 8, s, e, u);
    check_output("pre-reset err_count", int'(err_count), 1);
    apply_stimulus(0, 1, 8, s, e, u);
    apply_stimulus(1, 1, 8, s, e, u);
    check_output("pre-reset dir", int'(dir), 0);

    // reset while heading 11 -> 01 with the A filter counter at 2
    a_in = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check_output("midreset step", int'(step), 0);
    check_output("midreset dir", int'(dir), 1);
    check_output("midreset err", int'(err), 0);
    check_output("midreset err_count", int'(err_count), 0);
    a_in = 1'b1;
    b_in = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    apply_stimulus(1, 1, 20, s, e, u);
    check_output("settle steps", s, 0);
    check_output("settle errs", e, 0);
    check_output("settle dir", int'(dir), 1);
    apply_stimulus(1, 0, 10, s, e, u);
    check_output("post-settle steps", s, 1);
    check_output("post-settle ups", u, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
